axi_sram_slave_p: RTL
=====================

# axi_sram_slave_p

Parametrised AXI4 slave front-end for an on-chip single-port synchronous SRAM, the next generation of the lab SRAM wrapper. It sits behind the AXI interconnect as a memory slave. It adds the following over the previous wrapper:
- configurable depth
- FIXED/INCR/WRAP burst support
- SLVERR signalling for illegal or out-of-range accesses
- fair read/write arbitration
- a stall-safe read data path

The memory is an inferred `DEPTH_WORDS x 32` array with byte write enables and 1-cycle read latency.

## Interface
- `DEPTH_WORDS`, default 16384: number of 32-bit words; need not be a power of two. `IDX_W = $clog2(DEPTH_WORDS)`.
- `ACLK` in 1: clock; the only clock.
- `ARESETn` in 1: reset, asynchronous and active-low.
- `ARID_S`/`ARADDR_S`/`ARLEN_S`/`ARSIZE_S`/`ARBURST_S`/`ARVALID_S` in (`` `AXI_IDS_BITS ``/`` `AXI_ADDR_BITS ``/`` `AXI_LEN_BITS ``/`` `AXI_SIZE_BITS ``/2/1): read address channel.
- `ARREADY_S` out 1: read address ready.
- `RID_S`/`RDATA_S`/`RRESP_S`/`RLAST_S`/`RVALID_S` out (`` `AXI_IDS_BITS ``/`` `AXI_DATA_BITS ``/2/1/1): read data channel.
- `RREADY_S` in 1: read data ready.
- `AWID_S`/`AWADDR_S`/`AWLEN_S`/`AWSIZE_S`/`AWBURST_S`/`AWVALID_S` in: write address channel, same widths as the AR channel.
- `AWREADY_S` out 1: write address ready.
- `WDATA_S`/`WSTRB_S`/`WLAST_S`/`WVALID_S` in (`` `AXI_DATA_BITS ``/`` `AXI_STRB_BITS ``/1/1): write data channel.
- `WREADY_S` out 1: write data ready.
- `BID_S`/`BRESP_S`/`BVALID_S` out (`` `AXI_IDS_BITS ``/2/1): write response channel.
- `BREADY_S` in 1: write response ready.

## Operation
- **States:** IDLE, RD, WR, WRESP. Reset enters IDLE.
- **IDLE arbitration:**
  - `ARREADY_S = ARVALID_S & (~AWVALID_S | prio_rd)`.
  - `AWREADY_S = AWVALID_S & (~ARVALID_S | ~prio_rd)`.
  - At most one address is accepted per cycle.
  - `prio_rd` resets to 1 and toggles each time a contended grant is made, so the loser of a contended cycle wins the next one.
- **Transitions:**
  - IDLE goes to RD on AR handshake, or to WR on AW handshake.
  - RD goes to IDLE on `RVALID_S & RREADY_S & RLAST_S`.
  - WR goes to WRESP on the beat that completes `LEN+1` beats.
  - WRESP goes to IDLE on `BVALID_S & BREADY_S`.
- **Captured on address handshake:** ID, start address, LEN, BURST, and an error flag `err`.
  - `err` is set if SIZE ≠ 3'b010, or BURST = 2'b11, or BURST = WRAP with LEN ∉ {1,3,7,15}, or the start address is not word-aligned.
- **Beat address generation:**
  - FIXED: unchanged.
  - INCR: +4 per beat.
  - WRAP: +4 per beat, wrapping within an aligned `(LEN+1)*4` byte window. Example: start 0x38, LEN 3 gives 0x38, 0x3C, 0x30, 0x34.
- **Word index:** `addr[IDX_W+1:2]`; higher address bits are ignored. A beat whose index is ≥ `DEPTH_WORDS` is out of range.
- **Read beats:**
  - `RRESP_S` is SLVERR if `err` is set or the beat is out of range; otherwise OKAY.
  - Errored beats return `RDATA_S = 0`.
  - `RLAST_S` is asserted on beat LEN, counting from beat 0.
- **Write beats:**
  - Byte lane n is written iff `WSTRB_S[n]` is set.
  - Errored or out-of-range beats are not written but are still accepted.
  - `WLAST_S` does not end the burst. If `WLAST_S` disagrees with the final-beat position on any beat, a sticky SLVERR is set.
  - `BRESP_S` is SLVERR if any beat of the burst errored; otherwise OKAY.
- **Idle outputs:** `RID_S`, `RDATA_S`, `RRESP_S`, `BID_S` and `BRESP_S` are 0 outside their active states.

## Timing
- **During reset:** every output is 0, state is IDLE, `prio_rd` is 1, counters are 0. Memory contents are not cleared.
- **Reset asserted mid-burst:** all outputs drop to 0 immediately and the burst is abandoned.
- **Read latency:**
  - The memory address for beat 0 is driven in the AR handshake cycle, so `RVALID_S` rises the next cycle.
  - With `RREADY_S` held high, beats are back-to-back at one per cycle.
- **Read stall:** while `RVALID_S & ~RREADY_S`, `RDATA_S`, `RRESP_S` and `RLAST_S` hold stable across any number of cycles. A holding register captures SRAM Q, and the address of the next beat is presented only after the handshake.
- **Write throughput:** `WREADY_S` is 1 throughout WR, giving one beat per cycle. The memory write occurs in the handshake cycle.
- **Write response:** `BVALID_S` rises the cycle after the final W handshake and holds until `BREADY_S`.
- **Address readies:** `ARREADY_S` and `AWREADY_S` are 0 outside IDLE. A new address can be accepted the cycle after the RD or WRESP exit.

## Configuration
- `AXI_SRAM_WRAP_EN` defined: WRAP bursts are supported as described in Operation.
- `AXI_SRAM_WRAP_EN` undefined: BURST = 2'b10 sets `err`. All beats are still transferred, with no memory writes, reads returning 0, and SLVERR on every beat or in B.

## Test plan
- **INCR write then read:** write INCR LEN 3 at 0x100 with data 0xA0..0xA3, full strobe, expecting BRESP OKAY. Then read INCR LEN 3 at 0x100, expecting 0xA0..0xA3 on 4 consecutive cycles with RLAST on the 4th.
- **Partial strobe:** write 0xFFFFFFFF to 0x40, then write 0x12345678 to 0x40 with WSTRB 4'b0101. Read 0x40 and expect 0xFF34FF78.
- **Read stall:** read INCR LEN 2 with RREADY low for 3 cycles on beat 1. Expect RDATA, RRESP and RLAST stable for the whole stall, correct data on all 3 beats, and no skipped or duplicated beat.
- **Arbitration:** hold ARVALID and AWVALID together from reset, with LEN 0 each. Expect grants in the order read, write, read, write.
- **WRAP (macro defined):** preload words at 0x30..0x3C with 0x30..0x3C, then read WRAP LEN 3 at 0x38. Expect data 0x38, 0x3C, 0x30, 0x34. With the macro undefined, expect 4 beats of 0 with RRESP SLVERR.
- **Errors:**
  - ARSIZE 3'b001 gives SLVERR on every beat.
  - A write to word index `DEPTH_WORDS` gives BRESP SLVERR and leaves memory unchanged.
  - Reset asserted on beat 2 of a LEN 7 read forces RVALID to 0 immediately and returns the block to IDLE.

Source files
------------

// File: rtl/axi_sram_slave_p.sv
// axi_sram_slave_p
//   AXI4 slave front-end for an inferred single-port synchronous SRAM of
//   DEPTH_WORDS x 32 bits, with byte write enables and 1-cycle read latency.
//   Supports FIXED/INCR bursts, plus WRAP when AXI_SRAM_WRAP_EN is defined.
//   Without AXI_SRAM_WRAP_EN, WRAP bursts are treated as errors.
//   Illegal or out-of-range beats return SLVERR. Read and write address
//   requests are arbitrated round-robin.
// Ports:
//   ACLK, ARESETn          clock, asynchronous active-low reset
//   AR*_S / ARREADY_S      read address channel
//   R*_S  / RREADY_S       read data channel
//   AW*_S / AWREADY_S      write address channel
//   W*_S  / WREADY_S       write data channel
//   B*_S  / BREADY_S       write response channel
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif
`ifndef AXI_STRB_BITS
`define AXI_STRB_BITS 4
`endif

module axi_sram_slave_p #(
    parameter int unsigned DEPTH_WORDS = 16384
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [`AXI_IDS_BITS-1:0]  ARID_S,
    input  logic [`AXI_ADDR_BITS-1:0] ARADDR_S,
    input  logic [`AXI_LEN_BITS-1:0]  ARLEN_S,
    input  logic [`AXI_SIZE_BITS-1:0] ARSIZE_S,
    input  logic [1:0]                ARBURST_S,
    input  logic                      ARVALID_S,
    output logic                      ARREADY_S,
    output logic [`AXI_IDS_BITS-1:0]  RID_S,
    output logic [`AXI_DATA_BITS-1:0] RDATA_S,
    output logic [1:0]                RRESP_S,
    output logic                      RLAST_S,
    output logic                      RVALID_S,
    input  logic                      RREADY_S,
    input  logic [`AXI_IDS_BITS-1:0]  AWID_S,
    input  logic [`AXI_ADDR_BITS-1:0] AWADDR_S,
    input  logic [`AXI_LEN_BITS-1:0]  AWLEN_S,
    input  logic [`AXI_SIZE_BITS-1:0] AWSIZE_S,
    input  logic [1:0]                AWBURST_S,
    input  logic                      AWVALID_S,
    output logic                      AWREADY_S,
    input  logic [`AXI_DATA_BITS-1:0] WDATA_S,
    input  logic [`AXI_STRB_BITS-1:0] WSTRB_S,
    input  logic                      WLAST_S,
    input  logic                      WVALID_S,
    output logic                      WREADY_S,
    output logic [`AXI_IDS_BITS-1:0]  BID_S,
    output logic [1:0]                BRESP_S,
    output logic                      BVALID_S,
    input  logic                      BREADY_S
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned AW    = `AXI_ADDR_BITS;
    localparam int unsigned LW    = `AXI_LEN_BITS;
    localparam logic [1:0]  SLVERR = 2'b10;

    typedef enum logic [1:0] {StIdle, StRd, StWr, StWresp} state_t;

    state_t                    r_state, w_state_d;
    logic                      r_prio_rd;
    logic [`AXI_IDS_BITS-1:0]  r_id;
    logic [AW-1:0]             r_addr;
    logic [LW-1:0]             r_len, r_cnt;
    logic [1:0]                r_burst;
    logic                      r_err, r_rerr, r_berr;
    logic [31:0]               r_q;
    logic [31:0]               r_mem [DEPTH_WORDS];

    logic                      w_idle, w_ar_hs, w_aw_hs, w_r_hs, w_w_hs, w_last;
    logic                      w_ar_err, w_aw_err, w_rd_issue, w_rd_err, w_wr_err, w_ren, w_wen;
    logic [AW-1:0]             w_next, w_rd_addr;
    logic [IDX_W-1:0]          w_mem_idx;

    function automatic logic is_oor(input logic [IDX_W-1:0] idx);
        return 32'(idx) >= 32'(DEPTH_WORDS);
    endfunction

    function automatic logic addr_err(input logic [AW-1:0] a, input logic [LW-1:0] len,
                                      input logic [`AXI_SIZE_BITS-1:0] size,
                                      input logic [1:0] burst);
        logic e;
        e = (size != 3'b010) || (burst == 2'b11) || (a[1:0] != 2'b00);
`ifdef AXI_SRAM_WRAP_EN
        if (burst == 2'b10 && !(len == LW'(1) || len == LW'(3) || len == LW'(7) ||
                                len == LW'(15))) begin
            e = 1'b1;
        end
`else
        if (burst == 2'b10 || len != len) begin
            e = 1'b1;
        end
`endif
        return e;
    endfunction

    // WRAP keeps the upper bits of the aligned (LEN+1)*4 window; legal WRAP
    // lengths make (LEN+1)*4-1 equal to {LEN, 2'b11}.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                                 input logic [LW-1:0] len,
                                                 input logic [1:0] burst);
        logic [AW-1:0] inc, mask;
        inc  = a + AW'(4);
        mask = AW'({len, 2'b11});
        if (burst == 2'b00) begin
            return a;
        end
`ifdef AXI_SRAM_WRAP_EN
        if (burst == 2'b10) begin
            return (a & ~mask) | (inc & mask);
        end
`else
        if (mask == '0) begin
            return inc;
        end
`endif
        return inc;
    endfunction

    always_comb begin
        w_idle    = (r_state == StIdle) && ARESETn;
        ARREADY_S = w_idle & ARVALID_S & (~AWVALID_S | r_prio_rd);
        AWREADY_S = w_idle & AWVALID_S & (~ARVALID_S | ~r_prio_rd);
        w_ar_hs   = ARREADY_S;
        w_aw_hs   = AWREADY_S;
        w_last    = (r_cnt == r_len);
        w_r_hs    = (r_state == StRd) & RREADY_S;
        w_w_hs    = (r_state == StWr) & WVALID_S;
        w_ar_err  = addr_err(ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S);
        w_aw_err  = addr_err(AWADDR_S, AWLEN_S, AWSIZE_S, AWBURST_S);
        w_next    = next_addr(r_addr, r_len, r_burst);
        // Next read is issued only on a handshake so SRAM Q holds during a stall.
        w_rd_addr  = w_ar_hs ? ARADDR_S : w_next;
        w_rd_issue = w_ar_hs | (w_r_hs & ~w_last);
        w_rd_err   = w_ar_hs ? (w_ar_err | is_oor(ARADDR_S[IDX_W+1:2]))
                             : (r_err | is_oor(w_next[IDX_W+1:2]));
        w_ren      = w_rd_issue & ~w_rd_err;
        w_wr_err   = r_err | is_oor(r_addr[IDX_W+1:2]);
        w_wen      = w_w_hs & ~w_wr_err;
        w_mem_idx  = w_wen ? r_addr[IDX_W+1:2] : w_rd_addr[IDX_W+1:2];
    end

    // Next-state and response outputs.
    always_comb begin
        w_state_d = r_state;
        RVALID_S  = 1'b0;
        RID_S     = '0;
        RDATA_S   = '0;
        RRESP_S   = 2'b00;
        RLAST_S   = 1'b0;
        WREADY_S  = 1'b0;
        BVALID_S  = 1'b0;
        BID_S     = '0;
        BRESP_S   = 2'b00;
        unique case (r_state)
            StIdle: begin
                if (w_ar_hs) begin
                    w_state_d = StRd;
                end else if (w_aw_hs) begin
                    w_state_d = StWr;
                end
            end
            StRd: begin
                RVALID_S = 1'b1;
                RID_S    = r_id;
                RDATA_S  = r_rerr ? '0 : r_q;
                RRESP_S  = r_rerr ? SLVERR : 2'b00;
                RLAST_S  = w_last;
                if (w_r_hs && w_last) begin
                    w_state_d = StIdle;
                end
            end
            StWr: begin
                WREADY_S = 1'b1;
                if (w_w_hs && w_last) begin
                    w_state_d = StWresp;
                end
            end
            StWresp: begin
                BVALID_S = 1'b1;
                BID_S    = r_id;
                BRESP_S  = r_berr ? SLVERR : 2'b00;
                if (BREADY_S) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= StIdle;
            r_prio_rd <= 1'b1;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_burst   <= 2'b00;
            r_err     <= 1'b0;
            r_rerr    <= 1'b0;
            r_berr    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_idle && ARVALID_S && AWVALID_S) begin
                r_prio_rd <= ~r_prio_rd;
            end
            if (w_ar_hs) begin
                r_id    <= ARID_S;
                r_addr  <= ARADDR_S;
                r_len   <= ARLEN_S;
                r_burst <= ARBURST_S;
                r_err   <= w_ar_err;
                r_cnt   <= '0;
            end else if (w_aw_hs) begin
                r_id    <= AWID_S;
                r_addr  <= AWADDR_S;
                r_len   <= AWLEN_S;
                r_burst <= AWBURST_S;
                r_err   <= w_aw_err;
                r_cnt   <= '0;
                r_berr  <= 1'b0;
            end
            if (w_rd_issue) begin
                r_rerr <= w_rd_err;
            end
            if ((w_r_hs && !w_last) || w_w_hs) begin
                r_addr <= w_next;
                r_cnt  <= r_cnt + LW'(1);
            end
            // Sticky: any errored beat or misplaced WLAST fails the whole burst.
            if (w_w_hs) begin
                r_berr <= r_berr | w_wr_err | (WLAST_S != w_last);
            end
        end
    end

    // Single-port SRAM; read and write never coincide since RD/WR are exclusive.
    always_ff @(posedge ACLK) begin
        if (w_wen) begin
            for (int b = 0; b < 4; b++) begin
                if (WSTRB_S[b]) begin
                    r_mem[w_mem_idx][8*b +: 8] <= WDATA_S[8*b +: 8];
                end
            end
        end else if (w_ren) begin
            r_q <= r_mem[w_mem_idx];
        end
    end

endmodule
